// File: rtl/fir_lpf_pkg.sv
// Shared types and constants for the time-multiplexed FIR low-pass filter:
// default coefficient set, FSM state encoding and the output saturation helper.
package fir_lpf_pkg;

    localparam int COEF_W_DEF    = 18;
    localparam int COEF_FRAC_DEF = 15;
    localparam int DEF_NTAPS     = 16;
    localparam int SAT_W         = 128;

    // Symmetric low-pass kernel, taps sum to 32768 for unity DC gain.
    localparam logic signed [COEF_W_DEF-1:0] DEF_COEFS [DEF_NTAPS] = '{
        -18'sd100, -18'sd200,   18'sd0,  18'sd800,
         18'sd2000, 18'sd3500, 18'sd4600, 18'sd5784,
         18'sd5784, 18'sd4600, 18'sd3500, 18'sd2000,
         18'sd800,   18'sd0,  -18'sd200, -18'sd100
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_SCALE = 2'd2,
        ST_OUT   = 2'd3
    } fir_state_e;

    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] i_val,
        input int                      i_width
    );
        logic signed [SAT_W-1:0] lim_hi;
        logic signed [SAT_W-1:0] lim_lo;
        logic signed [SAT_W-1:0] res;
        lim_hi = (SAT_W'(1) <<< (i_width - 1)) - SAT_W'(1);
        lim_lo = -lim_hi - SAT_W'(1);
        if (i_val > lim_hi) begin
            res = lim_hi;
        end else if (i_val < lim_lo) begin
            res = lim_lo;
        end else begin
            res = i_val;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate: the product is registered one cycle before it is
// added, so the caller issues each tap one cycle ahead of its accumulation.
module fir_mac_unit #(
    parameter int A_W   = 24,
    parameter int B_W   = 18,
    parameter int ACC_W = 46
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic signed [A_W-1:0]   i_a,
    input  logic signed [B_W-1:0]   i_b,
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [A_W+B_W-1:0] r_prod;

    // Product pipeline register, loaded every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod <= '0;
        end else begin
            r_prod <= i_a * i_b;
        end
    end

    // Accumulator; clear wins over enable so a new sample always starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_acc <= '0;
        end else if (i_clr) begin
            o_acc <= '0;
        end else if (i_en) begin
            o_acc <= o_acc + ACC_W'(r_prod);
        end else begin
            o_acc <= o_acc;
        end
    end

endmodule

// File: rtl/fir_lpf_mac.sv
// Time-multiplexed FIR low-pass: one MAC walks a circular delay line per sample,
// then rounds, applies a gain shift and saturates; en=0 passes samples through.
module fir_lpf_mac
    import fir_lpf_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int COEF_W    = COEF_W_DEF,
    parameter int COEF_FRAC = COEF_FRAC_DEF,
    parameter int NTAPS     = 16,
    parameter int GAIN_W    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [GAIN_W-1:0]        gain,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] D_in,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] D_out
);

    localparam int PTR_W = $clog2(NTAPS);
    localparam int ACC_W = DATA_W + COEF_W + $clog2(NTAPS);
    localparam logic [PTR_W-1:0] LAST_TAP  = PTR_W'(NTAPS - 1);
    localparam logic [PTR_W:0]   NTAPS_EXT = (PTR_W + 1)'(NTAPS);
    localparam logic signed [ACC_W-1:0] RND = (ACC_W'(1)) << (COEF_FRAC - 1);

    fir_state_e                r_state;
    logic signed [DATA_W-1:0]  r_delay [NTAPS];
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_tap;
    logic signed [DATA_W-1:0]  r_sample;
    logic                      r_en;
    logic [GAIN_W-1:0]         r_gain;

    logic signed [COEF_W-1:0]  w_coef [NTAPS];
    logic [PTR_W:0]            w_tap_nx;
    logic [PTR_W:0]            w_ptr_ext;
    logic [PTR_W:0]            w_rd_full;
    logic [PTR_W-1:0]          w_rd_idx;
    logic signed [DATA_W-1:0]  w_mul_a;
    logic signed [COEF_W-1:0]  w_mul_b;
    logic                      w_acc_clr;
    logic                      w_acc_en;
    logic signed [ACC_W-1:0]   w_acc;
    logic signed [ACC_W-1:0]   w_round;
    logic signed [ACC_W-1:0]   w_shr;
    logic signed [SAT_W-1:0]   w_wide;
    logic signed [DATA_W-1:0]  w_scaled;

    // Taps beyond the default kernel length are zero.
    for (genvar g = 0; g < NTAPS; g++) begin : g_coef
        if (g < DEF_NTAPS) begin : g_def
            assign w_coef[g] = COEF_W'(DEF_COEFS[g]);
        end else begin : g_zero
            assign w_coef[g] = '0;
        end
    end

    // Operand select: tap 0 is issued from D_in at accept, tap k+1 during MAC cycle k.
    always_comb begin
        w_tap_nx  = {1'b0, r_tap} + {{PTR_W{1'b0}}, 1'b1};
        w_ptr_ext = {1'b0, r_wr_ptr};
        if (w_ptr_ext >= w_tap_nx) begin
            w_rd_full = w_ptr_ext - w_tap_nx;
        end else begin
            w_rd_full = w_ptr_ext + NTAPS_EXT - w_tap_nx;
        end
        w_rd_idx  = PTR_W'(w_rd_full);
        w_mul_a   = '0;
        w_mul_b   = '0;
        w_acc_clr = 1'b0;
        w_acc_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_mul_a   = D_in;
                w_mul_b   = w_coef[0];
                w_acc_clr = in_valid;
            end
            ST_MAC: begin
                w_acc_en = 1'b1;
                if (r_tap != LAST_TAP) begin
                    w_mul_a = r_delay[w_rd_idx];
                    w_mul_b = w_coef[PTR_W'(w_tap_nx)];
                end else begin
                    w_mul_a = '0;
                    w_mul_b = '0;
                end
            end
            default: begin
                w_mul_a = '0;
                w_mul_b = '0;
            end
        endcase
    end

    fir_mac_unit #(
        .A_W   (DATA_W),
        .B_W   (COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_acc_clr),
        .i_en  (w_acc_en),
        .i_a   (w_mul_a),
        .i_b   (w_mul_b),
        .o_acc (w_acc)
    );

    // Round half up, drop fraction, apply gain shift, clamp to the sample range.
    always_comb begin
        w_round  = w_acc + RND;
        w_shr    = w_round >>> COEF_FRAC;
        w_wide   = SAT_W'(w_shr) <<< r_gain;
        w_scaled = DATA_W'(saturate(w_wide, DATA_W));
    end

    // Sequencer, delay line and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_wr_ptr  <= '0;
            r_tap     <= '0;
            r_sample  <= '0;
            r_en      <= 1'b0;
            r_gain    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            D_out     <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                r_delay[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_delay[r_wr_ptr] <= D_in;
                        r_sample          <= D_in;
                        r_en              <= en;
                        r_gain            <= gain;
                        r_tap             <= '0;
                        in_ready          <= 1'b0;
                        r_state           <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (r_tap == LAST_TAP) begin
                        r_tap   <= '0;
                        r_state <= ST_SCALE;
                    end else begin
                        r_tap <= r_tap + PTR_W'(1);
                    end
                end
                ST_SCALE: begin
                    D_out     <= r_en ? w_scaled : r_sample;
                    out_valid <= 1'b1;
                    r_state   <= ST_OUT;
                end
                ST_OUT: begin
                    r_wr_ptr <= (r_wr_ptr == LAST_TAP) ? '0 : r_wr_ptr + PTR_W'(1);
                    in_ready <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_lpf_mac.sv
// Directed bench for fir_lpf_mac: impulse, DC, saturation, bypass, handshake
// and mid-computation reset scenarios with hand-derived expectations.
module tb_fir_lpf_mac;

    localparam int NTAPS  = 16;
    localparam int PERIOD = NTAPS + 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [2:0]         gain;
    logic               in_valid;
    logic               in_ready;
    logic signed [23:0] D_in;
    logic               out_valid;
    logic signed [23:0] D_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int coefs [16] = '{-100, -200, 0, 800, 2000, 3500, 4600, 5784,
                       5784, 4600, 3500, 2000, 800, 0, -200, -100};
    longint hist [$];

    fir_lpf_mac dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .gain      (gain),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D_in      (D_in),
        .out_valid (out_valid),
        .D_out     (D_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference filter over the accepted-sample history.
    function automatic logic signed [23:0] model(input int g);
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < NTAPS; k++) begin
            if (hist.size() > k) acc += longint'(coefs[k]) * hist[hist.size() - 1 - k];
        end
        r = (acc + 64'sd16384) >>> 15;
        r = r <<< g;
        if (r > 64'sd8388607) r = 64'sd8388607;
        else if (r < -64'sd8388608) r = -64'sd8388608;
        return r[23:0];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
    endtask

    task automatic send(input logic signed [23:0] x, input logic e, input logic [2:0] g,
                        output logic signed [23:0] y, output int t_out);
        int k;
        int t_acc;
        logic signed [23:0] prev;
        bit held;
        k = 0;
        y = '0;
        t_out = -1;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL send_ready: in_ready=%0b required 1 within 100 cycles", in_ready);
        end
        D_in = x; en = e; gain = g; in_valid = 1'b1;
        hist.push_back(longint'(x));
        t_acc = cyc;
        prev = D_out;
        held = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        en = ~e;
        gain = ~g;
        k = 0;
        while (k < 60) begin
            @(negedge clk);
            if (out_valid) begin
                y = D_out;
                t_out = cyc;
                break;
            end else if (D_out !== prev) begin
                held = 1'b0;
            end
            k++;
        end
        n_tests++;
        if (t_out - t_acc != NTAPS + 2) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles required %0d", t_out - t_acc, NTAPS + 2);
        end
        n_tests++;
        if (!held) begin
            n_fail++;
            $display("FAIL hold: D_out changed between pulses (now %0d, was %0d)", D_out, prev);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; gain = 3'd0; in_valid = 1'b0; D_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (D_out !== 24'sd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: D_out=%0d out_valid=%0b in_ready=%0b required 0/0/1", D_out, out_valid, in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_impulse();
        logic signed [23:0] y;
        logic signed [23:0] exp_v;
        int t;
        for (int i = 0; i < 17; i++) begin
            send((i == 0) ? 24'sd32768 : 24'sd0, 1'b1, 3'd0, y, t);
            exp_v = (i < 16) ? 24'(coefs[i]) : 24'sd0;
            n_tests++;
            if (y !== exp_v) begin
                n_fail++;
                $display("FAIL impulse[%0d]: got %0d expected %0d", i, y, exp_v);
            end
        end
    endtask

    task automatic test_dc();
        logic signed [23:0] y;
        int t;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send(24'sd1000, 1'b1, 3'd0, y, t);
            if (i == 0) begin
                n_tests++;
                if (y !== -24'sd3) begin
                    n_fail++;
                    $display("FAIL dc_first: got %0d expected -3", y);
                end
            end else if (i >= 15) begin
                n_tests++;
                if (y !== 24'sd1000) begin
                    n_fail++;
                    $display("FAIL dc[%0d]: got %0d expected 1000", i, y);
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [23:0] y;
        int t;
        for (int i = 0; i < 20; i++) begin
            send(24'sd8388607, 1'b1, 3'd3, y, t);
            if (i >= 15) begin
                n_tests++;
                if (y !== 24'sd8388607) begin
                    n_fail++;
                    $display("FAIL sat_pos[%0d]: got %0d expected 8388607", i, y);
                end
            end
        end
        for (int i = 0; i < 20; i++) begin
            send(-24'sd8388608, 1'b1, 3'd1, y, t);
            if (i >= 15) begin
                n_tests++;
                if (y !== -24'sd8388608) begin
                    n_fail++;
                    $display("FAIL sat_neg[%0d]: got %0d expected -8388608", i, y);
                end
            end
        end
    endtask

    task automatic test_bypass();
        logic signed [23:0] y;
        logic signed [23:0] x;
        logic signed [23:0] exp_v;
        int t;
        int t_prev;
        int s;
        do_reset();
        t_prev = -1;
        for (int i = 0; i < 66; i++) begin
            s = int'(120.0 * $sin(2.0 * 3.14159265358979 * real'(i % 64) / 64.0));
            x = 24'(s);
            if (i < 64) begin
                send(x, (i < 32) ? 1'b1 : 1'b0, 3'd2, y, t);
                exp_v = x;
            end else begin
                exp_v = '0;
                send(x, 1'b1, 3'd0, y, t);
                exp_v = model(0);
            end
            if (i >= 32) begin
                n_tests++;
                if (y !== exp_v) begin
                    n_fail++;
                    $display("FAIL bypass[%0d]: got %0d expected %0d", i, y, exp_v);
                end
            end
            if (t_prev >= 0) begin
                n_tests++;
                if (t - t_prev != PERIOD) begin
                    n_fail++;
                    $display("FAIL spacing[%0d]: got %0d cycles required %0d", i, t - t_prev, PERIOD);
                end
            end
            t_prev = t;
        end
    endtask

    task automatic test_back_to_back();
        logic signed [23:0] exp_q [$];
        logic signed [23:0] exp_v;
        int acc_n;
        int out_n;
        int last_rdy;
        do_reset();
        acc_n = 0; out_n = 0; last_rdy = -1;
        en = 1'b1; gain = 3'd0;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            if (out_valid) begin
                out_n++;
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 24'sd0;
                n_tests++;
                if (D_out !== exp_v) begin
                    n_fail++;
                    $display("FAIL b2b_out[%0d]: got %0d expected %0d", out_n, D_out, exp_v);
                end
            end
            if (i >= 80) begin
                in_valid = 1'b0;
            end else begin
                if (in_ready) begin
                    if (last_rdy >= 0) begin
                        n_tests++;
                        if (cyc - last_rdy != PERIOD) begin
                            n_fail++;
                            $display("FAIL b2b_ready_gap: got %0d cycles required %0d", cyc - last_rdy, PERIOD);
                        end
                    end
                    last_rdy = cyc;
                end
                D_in = 24'((i * 37 % 11) * 1000 - 4000 + i);
                in_valid = 1'b1;
                if (in_ready) begin
                    hist.push_back(longint'(D_in));
                    exp_q.push_back(model(0));
                    acc_n++;
                end
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (out_n != acc_n || acc_n != 5) begin
            n_fail++;
            $display("FAIL b2b_count: accepted %0d outputs %0d required 5 and 5", acc_n, out_n);
        end
    endtask

    task automatic test_reset_mid_mac();
        logic signed [23:0] y;
        int t;
        bit seen;
        do_reset();
        send(24'sd5000, 1'b1, 3'd0, y, t);
        n_tests++;
        if (y !== -24'sd15) begin
            n_fail++;
            $display("FAIL pre_abort: got %0d expected -15", y);
        end
        @(negedge clk);
        D_in = 24'sd7777; en = 1'b1; gain = 3'd0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || D_out !== 24'sd0) begin
            n_fail++;
            $display("FAIL abort_state: in_ready=%0b out_valid=%0b D_out=%0d required 1/0/0", in_ready, out_valid, D_out);
        end
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL abort_pulse: out_valid seen=%0b required 0", seen);
        end
        test_impulse();
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_saturation();
        test_bypass();
        test_back_to_back();
        test_reset_mid_mac();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
